load_data_extract: RTL
======================

// Module: load_data_extract
// PURPOSE
// - Load-side counterpart of the store write-data aligner. Sits in the MEM stage of the pipeline, between the load
//   request and the data memory, and feeds the WB stage.
// - Issues a word-aligned read, waits a variable number of cycles for memory, then selects the addressed word,
//   halfword or byte and sign- or zero-extends it.
// - Holds the pipeline stalled while a load is outstanding and flags misaligned or timed-out accesses.
// PARAMETERS
// - TIMEOUT_CYCLES  default 255  max cycles in WAIT before the access is aborted as a bus error
// - CNT_W           default 8    width of the wait counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
// - clk        in   1   single clock, rising edge
// - reset      in   1   synchronous, active-high
// - req_valid  in   1   load request present (MEM stage, load instruction)
// - req_addr   in   32  byte address of the load
// - req_type   in   3   000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101-111 illegal
// - mem_rdata  in   32  word returned by memory; valid when mem_ready=1
// - mem_ready  in   1   memory read data valid this cycle
// - mem_req    out  1   read strobe to memory
// - mem_addr   out  32  {addr[31:2],2'b00} of the latched request
// - rdata      out  32  extended load result
// - rdata_vld  out  1   one-cycle pulse: rdata is valid for WB
// - load_err   out  1   one-cycle pulse: misaligned, illegal type, or timeout
// - stall      out  1   freeze upstream pipeline stages
// BEHAVIOUR
// - Reset, sampled at a clk edge: state=IDLE, counter=0, latched addr/type=0.
//   All outputs are 0: mem_req, mem_addr, rdata, rdata_vld, load_err, stall.
// - FSM states: IDLE, WAIT, DONE, ERR.
// - IDLE with req_valid=1: latch req_addr and req_type.
//   - Misaligned or illegal request -> ERR. Misaligned means lw with addr[1:0]!=0, or lh/lhu with addr[0]=1.
//   - Otherwise -> WAIT.
// - IDLE with req_valid=0: stay in IDLE.
// - WAIT: mem_req=1 and mem_addr is held stable.
//   - mem_ready=1: register the extracted value into rdata and go to DONE. Minimum latency is request edge ->
//     WAIT -> DONE, so rdata_vld is asserted 2 cycles after req_valid is sampled.
//   - mem_ready=0: increment the counter. When the counter reaches TIMEOUT_CYCLES, go to ERR without capturing data.
//   - mem_ready and timeout in the same cycle: mem_ready wins.
// - DONE: rdata_vld=1 for one cycle -> IDLE. rdata holds its value until the next capture.
// - ERR: load_err=1 for one cycle and rdata cleared to 0 -> IDLE.
// - The counter is cleared on entry to WAIT.
// - stall = (state==WAIT) | (state==IDLE & req_valid). stall is 0 in DONE and ERR, so the load retires in that cycle.
// - req_valid is ignored in WAIT, DONE and ERR. The pipeline guarantees it is held by the stall; no new request is
//   accepted until IDLE.
// - Extraction uses lo=addr[1:0], little-endian byte lanes (the same lanes as the store aligner):
//   - lw: mem_rdata.
//   - lh/lhu: lo=0 -> [15:0], lo=2 -> [31:16]; sign-extend (lh) or zero-extend (lhu) to 32 bits.
//   - lb/lbu: byte [8*lo+7 : 8*lo]; sign-extend (lb) or zero-extend (lbu).
// - mem_rdata is sampled only in WAIT with mem_ready=1. Data at any other time is ignored.
// - reset asserted mid-operation (WAIT or DONE): next edge forces IDLE.
//   - mem_req drops that edge; no rdata_vld and no load_err are produced.
//   - A late mem_ready after reset is ignored.
// TESTING
// 1. lw addr=0x100, mem_ready on 1st WAIT cycle with rdata 0x8899AABB -> rdata=0x8899AABB, rdata_vld 2 cycles after
//    request; stall high 2 cycles.
// 2. lb addr=0x103 and lbu addr=0x103, word 0x80123456 -> lb gives 0xFFFFFF80, lbu gives 0x00000080;
//    mem_addr=0x100.
// 3. lh addr=0x202, word 0x8001_7FFF -> 0xFFFF8001; lhu same -> 0x00008001; lh addr=0x200 -> 0x00007FFF.
// 4. lw addr=0x101, or lh addr=0x203, or req_type=3'b111 -> ERR: load_err pulse, rdata=0, mem_req never asserted.
// 5. mem_ready held 0 with TIMEOUT_CYCLES=4 -> load_err after 4 WAIT cycles, stall then deasserts; a mem_ready
//    arriving in the timeout cycle instead completes normally.
// 6. reset asserted during WAIT, then mem_ready=1 on the next cycle -> IDLE, all outputs 0, no rdata_vld.
//    A following lbu addr=0x001 completes normally.

Source files
------------

// File: rtl/load_data_extract.sv
// Load-side data path: issues an aligned word read, waits for memory, then
// selects and sign/zero-extends the addressed word, halfword or byte.
//
// state | meaning
// IDLE  | no load outstanding; accepts a new request
// WAIT  | read strobe high, waiting for mem_ready or timeout
// DONE  | extracted data valid for writeback (one cycle)
// ERR   | misaligned, illegal type or timeout (one cycle)
module load_data_extract #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  input  logic [2:0]  req_type_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] rdata_o,
  output logic        rdata_vld_o,
  output logic        load_err_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_t;

  localparam logic [2:0] T_LW  = 3'b000;
  localparam logic [2:0] T_LH  = 3'b001;
  localparam logic [2:0] T_LHU = 3'b010;
  localparam logic [2:0] T_LB  = 3'b011;

  // The access times out on the WAIT cycle whose count equals TIMEOUT_CYCLES-1,
  // i.e. after exactly TIMEOUT_CYCLES cycles without mem_ready.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [2:0]        type_q, type_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              bad_req;
  logic [15:0]       half_sel;
  logic [7:0]        byte_sel;
  logic [31:0]       ext_data;

  always_comb begin
    bad_req = 1'b0;
    case (req_type_i)
      T_LW:         bad_req = (req_addr_i[1:0] != 2'b00);
      T_LH, T_LHU:  bad_req = req_addr_i[0];
      T_LB, 3'b100: bad_req = 1'b0;
      default:      bad_req = 1'b1;
    endcase
  end

  always_comb begin
    half_sel = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    byte_sel = mem_rdata_i[7:0];
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_rdata_i[7:0];
      2'd1:    byte_sel = mem_rdata_i[15:8];
      2'd2:    byte_sel = mem_rdata_i[23:16];
      default: byte_sel = mem_rdata_i[31:24];
    endcase
    ext_data = mem_rdata_i;
    case (type_q)
      T_LW:    ext_data = mem_rdata_i;
      T_LH:    ext_data = {{16{half_sel[15]}}, half_sel};
      T_LHU:   ext_data = {16'h0000, half_sel};
      T_LB:    ext_data = {{24{byte_sel[7]}}, byte_sel};
      default: ext_data = {24'h000000, byte_sel};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    type_d  = type_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d = req_addr_i;
          type_d = req_type_i;
          if (bad_req) begin
            state_d = S_ERR;
            rdata_d = 32'h0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (mem_ready_i) begin
          rdata_d = ext_data;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'h0;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      type_q  <= 3'b000;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_req_o   = (state_q == S_WAIT);
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign rdata_o     = rdata_q;
  assign rdata_vld_o = (state_q == S_DONE);
  assign load_err_o  = (state_q == S_ERR);
  assign stall_o     = (state_q == S_WAIT) | ((state_q == S_IDLE) & req_valid_i);

endmodule
